// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Brief    : TDM link receiver. Locks to the frame-sync marker and splits each
//            serial frame into N_CH parallel W-bit channels, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                din,
    input  logic                sync,
    output logic [N_CH*W-1:0]   ch_data,
    output logic                frame_valid,
    output logic                sync_err,
    output logic                locked
);

    localparam int             c_F    = N_CH * W;
    localparam int             c_CW   = (c_F > 1) ? $clog2(c_F) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_F - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [0:0] S_HUNT = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    logic [0:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [c_F-1:0]   r_buf;
    logic [c_F-1:0]   r_ch_data;
    logic             r_frame_valid;
    logic             r_sync_err;
    logic             r_locked;

    logic [c_F-1:0]   w_full;
    logic [c_F-1:0]   w_mapped;

    // r_buf is indexed by arrival order; the bit being sampled now completes it.
    always_comb begin
        w_full        = r_buf;
        w_full[c_F-1] = din;
    end

    // Arrival bit k*W+b is bit b (from the MSB) of channel k.
    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        for (genvar b = 0; b < W; b++) begin : g_bit
            assign w_mapped[k*W + W - 1 - b] = w_full[k*W + b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_HUNT;
            r_cnt         <= '0;
            r_buf         <= '0;
            r_ch_data     <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (en) begin
                case (r_state)
                    S_HUNT: begin
                        if (sync) begin
                            r_buf[0] <= din;
                            r_cnt    <= c_ONE;
                            r_state  <= S_RECV;
                        end
                    end
                    S_RECV: begin
                        if ((r_cnt == '0) && !sync) begin
                            r_sync_err <= 1'b1;
                            r_locked   <= 1'b0;
                            r_state    <= S_HUNT;
                        end else if ((r_cnt != '0) && sync) begin
                            // Early marker restarts the frame on this bit.
                            r_sync_err <= 1'b1;
                            r_locked   <= 1'b0;
                            r_buf[0]   <= din;
                            r_cnt      <= c_ONE;
                        end else begin
                            r_buf[r_cnt] <= din;
                            if (r_cnt == c_LAST) begin
                                r_cnt         <= '0;
                                r_ch_data     <= w_mapped;
                                r_frame_valid <= 1'b1;
                                r_locked      <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_HUNT;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign ch_data     = r_ch_data;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux
// Brief    : Directed self-checking bench for tdm_demux with a frame scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int F    = N_CH * W;

    localparam logic [F-1:0] c_F1 = {8'h01, 8'hFF, 8'h3C, 8'hA5};
    localparam logic [F-1:0] c_F2 = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    localparam logic [F-1:0] c_F3 = {8'h44, 8'h33, 8'h22, 8'h11};

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en = 1'b0;
    logic           din = 1'b0;
    logic           sync = 1'b0;
    logic [F-1:0]   ch_data;
    logic           frame_valid;
    logic           sync_err;
    logic           locked;

    int             checks = 0;
    int             errors = 0;
    int             n_fv = 0;
    int             n_se = 0;
    logic [F-1:0]   exp_q[$];
    logic [F-1:0]   r_exp;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .din         (din),
        .sync        (sync),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every frame_valid pulse consumes one expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("fv_se_exclusive", 64'(frame_valid & sync_err), 64'd0);
            if (sync_err === 1'b1) n_se++;
            if (frame_valid === 1'b1) begin
                n_fv++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 64'(frame_valid), 64'd0);
                end else begin
                    r_exp = exp_q.pop_front();
                    check("frame_data", 64'(ch_data), 64'(r_exp));
                end
            end
        end
    end

    task automatic send_bits(input logic [F-1:0] f, input int from, input int to,
                             input bit gap, input bit first_sync);
        for (int j = from; j <= to; j++) begin
            en   = 1'b1;
            din  = f[(j / W) * W + W - 1 - (j % W)];
            sync = (j == 0) ? first_sync : 1'b0;
            @(posedge clk); #1;
            en   = 1'b0;
            din  = 1'b0;
            sync = 1'b0;
            if (gap) begin
                sync = 1'b1;
                din  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                sync = 1'b0;
                din  = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ch_data", 64'(ch_data), 64'd0);
        check("rst_fv", 64'(frame_valid), 64'd0);
        check("rst_se", 64'(sync_err), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: plain frame
        exp_q.push_back(c_F1);
        send_bits(c_F1, 0, F-1, 1'b0, 1'b1);
        check("t1_fv", 64'(frame_valid), 64'd1);
        check("t1_data", 64'(ch_data), 64'(c_F1));
        check("t1_locked", 64'(locked), 64'd1);
        @(posedge clk); #1;
        check("t1_fv_drop", 64'(frame_valid), 64'd0);
        check("t1_nfv", 64'(n_fv), 64'd1);

        // 2: en toggling, sync held high during idle cycles
        exp_q.push_back(c_F1);
        send_bits(c_F1, 0, F-2, 1'b1, 1'b1);
        check("t2_no_early_fv", 64'(n_fv), 64'd1);
        send_bits(c_F1, F-1, F-1, 1'b0, 1'b1);
        check("t2_fv", 64'(frame_valid), 64'd1);
        check("t2_data", 64'(ch_data), 64'(c_F1));
        @(posedge clk); #1;
        check("t2_nfv", 64'(n_fv), 64'd2);
        check("t2_nse", 64'(n_se), 64'd0);

        // 3: missing sync
        send_bits(c_F2, 0, 0, 1'b0, 1'b0);
        check("t3_se", 64'(sync_err), 64'd1);
        check("t3_locked", 64'(locked), 64'd0);
        check("t3_hold", 64'(ch_data), 64'(c_F1));
        send_bits(c_F2, 1, F-1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t3_nfv", 64'(n_fv), 64'd2);
        check("t3_nse", 64'(n_se), 64'd1);
        check("t3_hold2", 64'(ch_data), 64'(c_F1));
        check("t3_locked2", 64'(locked), 64'd0);

        // 4: relock, then early sync at bit 13
        exp_q.push_back(c_F1);
        send_bits(c_F1, 0, F-1, 1'b0, 1'b1);
        check("t4_locked", 64'(locked), 64'd1);
        send_bits(c_F2, 0, 12, 1'b0, 1'b1);
        exp_q.push_back(c_F3);
        send_bits(c_F3, 0, 0, 1'b0, 1'b1);
        check("t4_se", 64'(sync_err), 64'd1);
        check("t4_unlocked", 64'(locked), 64'd0);
        send_bits(c_F3, 1, F-1, 1'b0, 1'b1);
        check("t4_fv", 64'(frame_valid), 64'd1);
        check("t4_data", 64'(ch_data), 64'(c_F3));
        check("t4_locked2", 64'(locked), 64'd1);
        @(posedge clk); #1;
        check("t4_nse", 64'(n_se), 64'd2);
        check("t4_nfv", 64'(n_fv), 64'd4);

        // 5: drop to HUNT, then sync with en=0 must be ignored
        send_bits(c_F1, 0, 0, 1'b0, 1'b0);
        check("t5_se", 64'(sync_err), 64'd1);
        sync = 1'b1;
        din  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        sync = 1'b0;
        din  = 1'b0;
        check("t5_nse", 64'(n_se), 64'd3);
        check("t5_locked", 64'(locked), 64'd0);
        check("t5_hold", 64'(ch_data), 64'(c_F3));
        send_bits(c_F2, 1, 1, 1'b0, 1'b0);
        exp_q.push_back(c_F1);
        send_bits(c_F1, 0, F-1, 1'b0, 1'b1);
        check("t5_data", 64'(ch_data), 64'(c_F1));
        check("t5_locked2", 64'(locked), 64'd1);
        @(posedge clk); #1;
        check("t5_nse2", 64'(n_se), 64'd3);
        check("t5_nfv", 64'(n_fv), 64'd5);

        // 6: asynchronous reset mid-frame
        send_bits(c_F3, 0, 19, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", 64'(ch_data), 64'd0);
        check("t6_rst_fv", 64'(frame_valid), 64'd0);
        check("t6_rst_se", 64'(sync_err), 64'd0);
        check("t6_rst_locked", 64'(locked), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(c_F3);
        send_bits(c_F3, 0, F-1, 1'b0, 1'b1);
        check("t6_fv", 64'(frame_valid), 64'd1);
        check("t6_data", 64'(ch_data), 64'(c_F3));
        check("t6_locked", 64'(locked), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t6_nfv", 64'(n_fv), 64'd6);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
